fifo_wr_arbiter: RTL

//  Shares the single write port of the async FIFO among NUM_REQ requester interfaces.

---
 rtl/fifo_wr_arbiter_pkg.sv | 22 ++
 rtl/fifo_wr_arbiter_if.sv | 36 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 66 ++++++
 rtl/fifo_wr_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO write-port arbiter.
//   arb_state_t  - arbiter FSM states (IDLE, WRITE, RELEASE)
//   NUM_REQ_DEF  - default number of requesters
//   DW_DEF       - default data width per requester / FIFO word
//   gid_w()      - width of the grant index for a given requester count
package fifo_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 2;
    localparam int unsigned DW_DEF      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RELEASE
    } arb_state_t;

    // A single requester still needs a 1-bit index.
    function automatic int unsigned gid_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester bundle plus FIFO write port.
//   req      - per-requester request level
//   data     - packed requester data, requester i at [i*DW +: DW]
//   wfull    - FIFO full flag (write domain)
//   winc     - FIFO write strobe
//   wdata    - FIFO write data
//   ack      - one-hot acknowledge to the winner
//   grant_id - index of last/current winner
// Modports: master = arbiter side, slave = requesters/FIFO side.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DW      = DW_DEF
);
    localparam int unsigned GW = gid_w(NUM_REQ);

    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] data;
    logic                  wfull;
    logic                  winc;
    logic [DW-1:0]         wdata;
    logic [NUM_REQ-1:0]    ack;
    logic [GW-1:0]         grant_id;

    modport master (
        input  req, data, wfull,
        output winc, wdata, ack, grant_id
    );

    modport slave (
        output req, data, wfull,
        input  winc, wdata, ack, grant_id
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational winner picker.
//   i_req     - request vector
//   i_ptr     - round-robin search start
//   o_any     - at least one request present
//   o_onehot  - one-hot winner
//   o_idx     - winner index
//   o_ptr_nxt - pointer value to load if this winner is granted
// Macro ARB_FIXED_PRIO_EN: lowest index always wins and the pointer is frozen.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned GW      = gid_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GW-1:0]      i_ptr,
    output logic               o_any,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [GW-1:0]      o_idx,
    output logic [GW-1:0]      o_ptr_nxt
);

    logic [GW-1:0] w_base;
    logic          w_hi_found;
    logic          w_lo_found;
    logic [GW-1:0] w_hi_idx;
    logic [GW-1:0] w_lo_idx;

`ifdef ARB_FIXED_PRIO_EN
    assign w_base    = '0;
    assign o_ptr_nxt = i_ptr;
`else
    assign w_base    = i_ptr;
    assign o_ptr_nxt = (o_idx == GW'(NUM_REQ - 1)) ? '0 : o_idx + GW'(1);
`endif

    // Wrap-around search split in two linear scans: first hit at or above
    // the base wins; otherwise the first hit from index 0.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (i_req[j] && !w_hi_found && (GW'(j) >= w_base)) begin
                w_hi_found = 1'b1;
                w_hi_idx   = GW'(j);
            end
            if (i_req[j] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = GW'(j);
            end
        end
    end

    assign o_any = |i_req;
    assign o_idx = w_hi_found ? w_hi_idx : w_lo_idx;

    always_comb begin
        o_onehot = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            o_onehot[j] = o_any && (o_idx == GW'(j));
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the single FIFO write port among NUM_REQ requesters.
// One winner per arbitration, one write strobe and one-cycle ack, then wait
// for the winner to drop req before arbitrating again.
//   clk_1 - write-domain clock
//   reset - asynchronous active-low reset
//   bus   - fifo_wr_arbiter_if.master (req/data/wfull in, winc/wdata/ack/grant_id out)
// All outputs are registered.
// Macro ARB_FIXED_PRIO_EN (inside rr_pick): fixed lowest-index priority.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DW      = DW_DEF
) (
    input  logic              clk_1,
    input  logic              reset,
    fifo_wr_arbiter_if.master bus
);

    localparam int unsigned GW = gid_w(NUM_REQ);

    arb_state_t         r_state;
    logic               r_winc;
    logic [DW-1:0]      r_wdata;
    logic [NUM_REQ-1:0] r_ack;
    logic [GW-1:0]      r_gid;
    logic [GW-1:0]      r_ptr;

    arb_state_t         w_state_nxt;
    logic               w_winc_nxt;
    logic [DW-1:0]      w_wdata_nxt;
    logic [NUM_REQ-1:0] w_ack_nxt;
    logic [GW-1:0]      w_gid_nxt;
    logic [GW-1:0]      w_ptr_nxt;

    logic               w_any;
    logic [NUM_REQ-1:0] w_onehot;
    logic [GW-1:0]      w_idx;
    logic [GW-1:0]      w_ptr_adv;
    logic [DW-1:0]      w_sel_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_pick (
        .i_req     (bus.req),
        .i_ptr     (r_ptr),
        .o_any     (w_any),
        .o_onehot  (w_onehot),
        .o_idx     (w_idx),
        .o_ptr_nxt (w_ptr_adv)
    );

    always_comb begin
        w_sel_data = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (w_onehot[j]) begin
                w_sel_data = bus.data[j*DW +: DW];
            end
        end
    end

    // wdata/grant_id hold their last value; only winc qualifies wdata.
    always_comb begin
        w_state_nxt = r_state;
        w_winc_nxt  = 1'b0;
        w_ack_nxt   = '0;
        w_wdata_nxt = r_wdata;
        w_gid_nxt   = r_gid;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_any && !bus.wfull) begin
                    w_state_nxt = WRITE;
                    w_winc_nxt  = 1'b1;
                    w_ack_nxt   = w_onehot;
                    w_wdata_nxt = w_sel_data;
                    w_gid_nxt   = w_idx;
                    w_ptr_nxt   = w_ptr_adv;
                end
            end
            WRITE: begin
                w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!bus.req[r_gid]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_winc  <= 1'b0;
            r_wdata <= '0;
            r_ack   <= '0;
            r_gid   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_winc  <= w_winc_nxt;
            r_wdata <= w_wdata_nxt;
            r_ack   <= w_ack_nxt;
            r_gid   <= w_gid_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign bus.winc     = r_winc;
    assign bus.wdata    = r_wdata;
    assign bus.ack      = r_ack;
    assign bus.grant_id = r_gid;

endmodule
